// File: rtl/instruction_encoder_if.sv
// -----------------------------------------------------------------------------
// instruction_encoder_if
// Request and output-buffer signals of the RV32I instruction encoder.
//   Request side : req_valid_i / req_ready_o handshake plus the decoded fields
//                  format_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i
//                  and the sign-extended immediate imm_i.
//   Output side  : out_valid_o / out_ready_i handshake plus the head entry
//                  (instr_word_o, instr_addr_o, imm_err_o, rt_mismatch_o) and
//                  the saturating error counter err_count_o.
// Modports: slave = the encoder, master = the loader / consumer side.
// -----------------------------------------------------------------------------
interface instruction_encoder_if;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [2:0]         format_i;
    logic [6:0]         opcode_i;
    logic [4:0]         rd_i;
    logic [4:0]         rs1_i;
    logic [4:0]         rs2_i;
    logic [2:0]         funct3_i;
    logic [6:0]         funct7_i;
    logic signed [31:0] imm_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [31:0]        instr_word_o;
    logic [31:0]        instr_addr_o;
    logic               imm_err_o;
    logic [7:0]         err_count_o;
    logic               rt_mismatch_o;

    modport slave (
        input  req_valid_i, format_i, opcode_i, rd_i, rs1_i, rs2_i,
               funct3_i, funct7_i, imm_i, out_ready_i,
        output req_ready_o, out_valid_o, instr_word_o, instr_addr_o,
               imm_err_o, err_count_o, rt_mismatch_o
    );

    modport master (
        output req_valid_i, format_i, opcode_i, rd_i, rs1_i, rs2_i,
               funct3_i, funct7_i, imm_i, out_ready_i,
        input  req_ready_o, out_valid_o, instr_word_o, instr_addr_o,
               imm_err_o, err_count_o, rt_mismatch_o
    );
endinterface

// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
// Packs decoded RV32I fields plus a sign-extended immediate into an
// instruction word, tags it with an auto-incrementing address and queues it
// in a 2-entry output buffer with valid/ready on both sides.
// Ports:
//   clk_i      system clock (rising edge)
//   rst_ni     asynchronous active-low reset
//   restart_i  synchronous pulse: address counter -> BASE_ADDR, error count
//              cleared; buffered entries kept
//   bus        instruction_encoder_if.slave (request fields + buffer head)
// Optional build macro: ENCODER_ROUNDTRIP_CHECK_EN adds a decode path that
// re-extracts the immediate from each encoded word and flags disagreement on
// rt_mismatch_o; without it rt_mismatch_o is tied low.
// -----------------------------------------------------------------------------
module instruction_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 restart_i,
    instruction_encoder_if.slave bus
);

    localparam logic [2:0]  FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                            FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_t;

    function automatic logic [31:0] encode_word(
        input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
        input logic [6:0] f7, input logic signed [31:0] imm);
        case (fmt)
            FMT_R:   encode_word = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   encode_word = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   encode_word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   encode_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   encode_word = {imm[31:12], rd, op};
            FMT_J:   encode_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: encode_word = NOP_WORD;
        endcase
    endfunction

    // Immediate must survive truncation to the format's field (sign bits all
    // equal) and, for branch/jump offsets, be halfword aligned.
    function automatic logic imm_range_err(input logic [2:0] fmt,
                                           input logic signed [31:0] imm);
        case (fmt)
            FMT_R:        imm_range_err = 1'b0;
            FMT_I, FMT_S: imm_range_err = (imm[31:11] != {21{imm[31]}});
            FMT_B:        imm_range_err = (imm[31:12] != {20{imm[31]}}) | imm[0];
            FMT_U:        imm_range_err = (imm[11:0] != 12'd0);
            FMT_J:        imm_range_err = (imm[31:20] != {12{imm[31]}}) | imm[0];
            default:      imm_range_err = 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        sat_inc = (inc && v != 8'hFF) ? v + 8'd1 : v;
    endfunction

    state_t       state_q, state_d;
    logic         ready_p0, vld_p1;
    logic         accept_p0, pop_p1;
    logic         load_head, load_tail, shift_head;
    logic [31:0]  word_p0, addr_p0;
    logic         err_p0;
    logic [31:0]  addr_cnt_q;
    logic [7:0]   err_cnt_q;
    logic [31:0]  word_p1 [2];
    logic [31:0]  addr_p1 [2];
    logic         err_p1  [2];

    // ---- stage p0: combinational encode of the presented request ----
    assign accept_p0 = bus.req_valid_i & ready_p0;
    assign pop_p1    = vld_p1 & bus.out_ready_i;
    assign word_p0   = encode_word(bus.format_i, bus.opcode_i, bus.rd_i, bus.rs1_i,
                                   bus.rs2_i, bus.funct3_i, bus.funct7_i, bus.imm_i);
    assign err_p0    = imm_range_err(bus.format_i, bus.imm_i);
    // A restart on the accepting edge tags this entry with BASE_ADDR.
    assign addr_p0   = restart_i ? BASE_ADDR : addr_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_EMPTY;
            addr_cnt_q <= BASE_ADDR;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            if (accept_p0)
                addr_cnt_q <= addr_p0 + ADDR_STEP;
            else if (restart_i)
                addr_cnt_q <= BASE_ADDR;
            err_cnt_q  <= sat_inc(restart_i ? 8'd0 : err_cnt_q, accept_p0 & err_p0);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept_p0) state_d = ST_ONE;
            ST_ONE: begin
                if (accept_p0 && !pop_p1)      state_d = ST_TWO;
                else if (!accept_p0 && pop_p1) state_d = ST_EMPTY;
            end
            ST_TWO:   if (pop_p1) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        ready_p0 = 1'b1;
        vld_p1   = 1'b0;
        case (state_q)
            ST_EMPTY: ;
            ST_ONE:   vld_p1 = 1'b1;
            ST_TWO: begin
                ready_p0 = 1'b0;
                vld_p1   = 1'b1;
            end
            default:  ready_p0 = 1'b0;
        endcase
    end

    // Slot 0 is always the head; a simultaneous accept+pop in ONE replaces it.
    assign load_head  = accept_p0 & ((state_q == ST_EMPTY) | ((state_q == ST_ONE) & pop_p1));
    assign load_tail  = accept_p0 & (state_q == ST_ONE) & ~pop_p1;
    assign shift_head = pop_p1 & (state_q == ST_TWO);

    // ---- stage p1: 2-entry output buffer ----
    always_ff @(posedge clk_i) begin
        if (load_head) begin
            word_p1[0] <= word_p0;
            addr_p1[0] <= addr_p0;
            err_p1[0]  <= err_p0;
        end else if (shift_head) begin
            word_p1[0] <= word_p1[1];
            addr_p1[0] <= addr_p1[1];
            err_p1[0]  <= err_p1[1];
        end
        if (load_tail) begin
            word_p1[1] <= word_p0;
            addr_p1[1] <= addr_p0;
            err_p1[1]  <= err_p0;
        end
    end

    assign bus.req_ready_o  = ready_p0;
    assign bus.out_valid_o  = vld_p1;
    assign bus.instr_word_o = vld_p1 ? word_p1[0] : 32'd0;
    assign bus.instr_addr_o = vld_p1 ? addr_p1[0] : 32'd0;
    assign bus.imm_err_o    = vld_p1 & err_p1[0];
    assign bus.err_count_o  = err_cnt_q;

`ifdef ENCODER_ROUNDTRIP_CHECK_EN
    // Immediate-generator extraction; opcode bits [6:0] play no part.
    function automatic logic signed [31:0] decode_imm(input logic [2:0] fmt,
                                                      input logic [31:7] w);
        case (fmt)
            FMT_I:   decode_imm = {{20{w[31]}}, w[31:20]};
            FMT_S:   decode_imm = {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:   decode_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FMT_U:   decode_imm = {w[31:12], 12'd0};
            FMT_J:   decode_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: decode_imm = 32'sd0;
        endcase
    endfunction

    logic signed [31:0] rt_ref_p0;
    logic               rt_p0;
    logic               rt_p1 [2];

    always_comb begin
        rt_ref_p0 = (bus.format_i == FMT_U) ? {bus.imm_i[31:12], 12'd0} : bus.imm_i;
        rt_p0     = 1'b0;
        if (!err_p0 && bus.format_i != FMT_R)
            rt_p0 = (decode_imm(bus.format_i, word_p0[31:7]) != rt_ref_p0);
    end

    always_ff @(posedge clk_i) begin
        if (load_head)       rt_p1[0] <= rt_p0;
        else if (shift_head) rt_p1[0] <= rt_p1[1];
        if (load_tail)       rt_p1[1] <= rt_p0;
    end

    assign bus.rt_mismatch_o = vld_p1 & rt_p1[0];
`else
    assign bus.rt_mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] STEP = 32'd4;

    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
        logic        e;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic restart = 1'b0;
    int   total = 0;
    int   bad = 0;

    ent_t        q[$];
    logic [31:0] cnt = BASE;
    int          ecnt = 0;

    instruction_encoder_if bus();

    instruction_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .restart_i(restart),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Field placement written as shift/mask arithmetic on the ISA bit positions.
    function automatic logic [31:0] ref_word(input logic [31:0] fmt, op, rd, rs1, rs2,
                                             f3, f7, imm);
        logic [31:0] regs;
        regs = (rs2 << 20) | (rs1 << 15) | (f3 << 12);
        case (fmt)
            0: return (f7 << 25) | regs | (rd << 7) | op;
            1: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            2: return (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7) | op;
            3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs
                      | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | op;
            4: return (imm & 32'hFFFF_F000) | (rd << 7) | op;
            5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                      | (rd << 7) | op;
            default: return 32'h0000_0013;
        endcase
    endfunction

    // Range rules as signed numeric intervals and alignment.
    function automatic logic ref_err(input logic [31:0] fmt, input logic [31:0] imm);
        longint s;
        logic odd;
        s = longint'($signed(imm));
        odd = imm[0];
        case (fmt)
            0:    return 1'b0;
            1, 2: return !(s >= -2048 && s <= 2047);
            3:    return !(s >= -4096 && s <= 4095) || odd;
            4:    return (imm % 4096) != 0;
            5:    return !(s >= -(64'sd1 << 20) && s < (64'sd1 << 20)) || odd;
            default: return 1'b1;
        endcase
    endfunction

    task automatic req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
        bus.format_i = fmt;  bus.opcode_i = op;   bus.rd_i = rd;
        bus.rs1_i = rs1;     bus.rs2_i = rs2;     bus.funct3_i = f3;
        bus.funct7_i = f7;   bus.imm_i = imm;     bus.req_valid_i = 1'b1;
    endtask

    // One clock: check outputs against the model on the falling edge, then
    // advance the model by whatever handshakes happen on the rising edge.
    task automatic cycle();
        logic acc, pop;
        ent_t e;
        @(negedge clk);
        chk("out_valid", bus.out_valid_o, q.size() > 0);
        chk("req_ready", bus.req_ready_o, q.size() < 2);
        chk("err_count", bus.err_count_o, ecnt);
        chk("rt_mismatch", bus.rt_mismatch_o, 0);
        if (q.size() > 0) begin
            chk("head_word", bus.instr_word_o, q[0].w);
            chk("head_addr", bus.instr_addr_o, q[0].a);
            chk("head_err", bus.imm_err_o, q[0].e);
        end
        acc = bus.req_valid_i && (q.size() < 2);
        pop = bus.out_ready_i && (q.size() > 0);
        @(posedge clk);
        if (restart) begin
            cnt = BASE;
            ecnt = 0;
        end
        if (pop) void'(q.pop_front());
        if (acc) begin
            e.w = ref_word(bus.format_i, bus.opcode_i, bus.rd_i, bus.rs1_i, bus.rs2_i,
                           bus.funct3_i, bus.funct7_i, bus.imm_i);
            e.e = ref_err(bus.format_i, bus.imm_i);
            e.a = cnt;
            cnt = cnt + STEP;
            if (e.e && ecnt != 255) ecnt++;
            q.push_back(e);
        end
        #1;
    endtask

    task automatic restart_pulse();
        restart = 1'b1;
        cycle();
        restart = 1'b0;
    endtask

    initial begin
        logic [31:0] imm_r;
        logic [2:0]  fmt_r;

        bus.req_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        bus.req_valid_i = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", bus.out_valid_o, 0);
        chk("rst_word", bus.instr_word_o, 0);
        chk("rst_addr", bus.instr_addr_o, 0);
        chk("rst_err", bus.imm_err_o, 0);
        chk("rst_errcnt", bus.err_count_o, 0);
        chk("rst_rt", bus.rt_mismatch_o, 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", bus.req_ready_o, 1);

        // I-type addi x1, x2, -1
        bus.out_ready_i = 1'b0;
        req(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        cycle();
        bus.req_valid_i = 1'b0;
        chk("i_word", bus.instr_word_o, 32'hFFF1_0093);
        chk("i_addr", bus.instr_addr_o, BASE);
        chk("i_err", bus.imm_err_o, 0);
        chk("i_rt", bus.rt_mismatch_o, 0);
        bus.out_ready_i = 1'b1;
        cycle();

        // S then B back to back
        restart_pulse();
        bus.out_ready_i = 1'b0;
        req(3'd2, 7'h23, 5'd0, 5'd10, 5'd5, 3'd2, 7'd0, 32'd4);
        cycle();
        req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        cycle();
        bus.req_valid_i = 1'b0;
        chk("s_word", bus.instr_word_o, 32'h0055_2223);
        chk("s_addr", bus.instr_addr_o, 32'd0);
        bus.out_ready_i = 1'b1;
        cycle();
        chk("b_word", bus.instr_word_o, 32'hFE20_8EE3);
        chk("b_addr", bus.instr_addr_o, 32'd4);
        chk("b_err", bus.imm_err_o, 0);
        cycle();

        // U and J with the consumer always ready
        req(3'd4, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        cycle();
        chk("u_word", bus.instr_word_o, 32'h1234_5537);
        req(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        cycle();
        chk("j_word", bus.instr_word_o, 32'h0010_006F);
        chk("j_err", bus.imm_err_o, 0);
        bus.req_valid_i = 1'b0;
        cycle();

        // Backpressure: three requests against a stalled consumer
        restart_pulse();
        bus.out_ready_i = 1'b0;
        req(3'd1, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd5);
        cycle();
        req(3'd1, 7'h13, 5'd6, 5'd7, 5'd0, 3'd0, 7'd0, 32'd9);
        cycle();
        chk("bp_ready", bus.req_ready_o, 0);
        req(3'd1, 7'h13, 5'd8, 5'd9, 5'd0, 3'd0, 7'd0, 32'd12);
        cycle();
        cycle();
        chk("bp_hold_word", bus.instr_word_o, 32'h0052_0193);
        chk("bp_hold_addr", bus.instr_addr_o, 32'd0);
        bus.out_ready_i = 1'b1;
        cycle();
        chk("bp_second_addr", bus.instr_addr_o, 32'd4);
        cycle();
        bus.req_valid_i = 1'b0;
        chk("bp_third_addr", bus.instr_addr_o, 32'd8);
        cycle();

        // Error cases
        restart_pulse();
        req(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048);
        cycle();
        chk("e_i_err", bus.imm_err_o, 1);
        req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        cycle();
        chk("e_b_err", bus.imm_err_o, 1);
        req(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        cycle();
        bus.req_valid_i = 1'b0;
        chk("e_nop_word", bus.instr_word_o, 32'h0000_0013);
        chk("e_nop_err", bus.imm_err_o, 1);
        chk("e_count", bus.err_count_o, 3);
        cycle();
        restart_pulse();
        chk("e_count_clr", bus.err_count_o, 0);
        req(3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1);
        cycle();
        bus.req_valid_i = 1'b0;
        chk("e_restart_addr", bus.instr_addr_o, BASE);
        cycle();

        // Async reset with two entries buffered (one errored)
        bus.out_ready_i = 1'b0;
        req(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd4096);
        cycle();
        req(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd7);
        cycle();
        bus.req_valid_i = 1'b0;
        chk("ar_pre_valid", bus.out_valid_o, 1);
        chk("ar_pre_count", bus.err_count_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.out_valid_o, 0);
        chk("ar_count", bus.err_count_o, 0);
        q.delete();
        cnt = BASE;
        ecnt = 0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b1;
        req(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
        cycle();
        bus.req_valid_i = 1'b0;
        chk("ar_next_addr", bus.instr_addr_o, BASE);
        cycle();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            fmt_r = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: imm_r = $urandom;
                1: imm_r = $urandom_range(0, 8191) - 4096;
                2: imm_r = ($urandom_range(0, 32'h20_0000) - 32'h10_0000) & ~32'd1;
                3: imm_r = $urandom & 32'hFFFF_F000;
                default: imm_r = $urandom_range(0, 4095) - 2048;
            endcase
            req(fmt_r, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                3'($urandom), 7'($urandom), imm_r);
            bus.req_valid_i = ($urandom_range(0, 3) != 0);
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            restart = ($urandom_range(0, 31) == 0);
            cycle();
        end
        restart = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
